aes_kexp_state: RTL and testbench
=================================

AES_KEXP_STATE -- requirements
Module: aes_kexp_state

Interface
REQ-001 SHALL use shared constant Nb, default 4, meaning state columns (32-bit words) per block.
REQ-002 SHALL use shared constant Nk, default 4, meaning key length in words (4/6/8 legal).
REQ-003 SHALL use shared constant Nr, default 10, meaning round count (Nk+6).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port SBox  input  8 x [0:255]  forward S-box table.
REQ-007 SHALL have port Key_in  input  8 x [0:4*Nk-1]  cipher key bytes; byte 0 is first key byte.
REQ-008 SHALL have port Start  input  1  request to expand Key_in.
REQ-009 SHALL have port KExp  output  32 x [0:Nb*(Nr+1)-1]  expanded key words, consumed by the round-key-add stage of the cipher/inverse cipher.
REQ-010 SHALL have port Busy  output  1  expansion in progress.
REQ-011 SHALL have port Ready_out  output  1  KExp complete and stable.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-013 IDLE/DONE with Start=1 at an edge: SHALL load words 0..Nk-1 as w[i]={Key_in[4i],Key_in[4i+1],Key_in[4i+2],Key_in[4i+3]}, set index i=Nk, Rcon=0x01, Ready_out=0, Busy=1, enter EXPAND.
REQ-014 EXPAND: SHALL compute exactly one word per cycle: temp=w[i-1]; if i mod Nk==0, temp=SubWord(RotWord(temp)) xor {Rcon,24'h0} and Rcon<=xtime(Rcon); else if Nk>6 and i mod Nk==4, temp=SubWord(temp); w[i]=w[i-Nk] xor temp; i<=i+1.
REQ-015 RotWord SHALL rotate bytes left by one ({b0,b1,b2,b3}->{b1,b2,b3,b0}); SubWord SHALL apply SBox to each byte.
REQ-016 xtime SHALL be {Rcon[6:0],1'b0} xor (Rcon[7] ? 0x1b : 0x00); Rcon register 8 bits.
REQ-017 Index register SHALL be wide enough for Nb*(Nr+1)-1 (6 bits); no wrap within an expansion.
REQ-018 On the edge writing word Nb*(Nr+1)-1, SHALL enter DONE with Ready_out=1, Busy=0.
REQ-019 Latency: Ready_out SHALL rise at edge Nb*(Nr+1)-Nk+1 counted from the edge sampling Start (41 for AES-128, 53 for AES-256).
REQ-020 DONE: Ready_out SHALL stay high and KExp unchanged until next Start.
REQ-021 Start during EXPAND SHALL be ignored; expansion continues unchanged.
REQ-022 Start in DONE SHALL restart per REQ-013 (Ready_out low after that edge).
REQ-023 Key_in SHALL be sampled only at the Start edge; later changes SHALL not affect KExp.
REQ-024 KExp words not yet written in EXPAND SHALL hold prior values; consumers use KExp only while Ready_out=1.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, Busy=0, Ready_out=0, i=0, Rcon=0x01, all KExp words 0, including mid-EXPAND.
REQ-026 rst SHALL take priority over simultaneous Start.

Structure
REQ-027 Nb, Nk, Nr SHALL reside in package aes_const; FSM state enum and reg_type in aes_wire.
REQ-028 SubWord SHALL be sub-module aes_subword (combinational, 4 SBox lookups, ports State_in/SBox/State_out 32-bit word).
REQ-029 FSM registers SHALL use the r/rin two-process form; KExp array in a separate clocked process.

Verification
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c, Start one cycle -> w[4]=a0fafe17, w[40]=d014f9a8, w[43]=b6630ca6, Ready_out at edge 41.
REQ-031 All-zero key -> w[4]=62636363, w[43]=6f8f188e; then Start again from DONE with A.1 key -> Ready_out low for 41 edges, A.1 results.
REQ-032 Start pulsed at edges 5 and 17 during EXPAND, Key_in changed -> results identical to REQ-030, Ready at edge 41.
REQ-033 rst asserted at edge 20 of expansion -> next cycle Busy=0, Ready_out=0, KExp all zero; restart yields REQ-030 values.
REQ-034 Nk=8 build, key 603deb10...0914dff4 -> w[8]=9ba35411, w[59]=706c631e, Ready_out at edge 53.

Source files
------------

// File: rtl/aes_kexp_state_pkg.sv
// Shared AES constants and key-expansion state types.
// aes_const holds block geometry; aes_wire holds FSM types.
package aes_const;
   localparam int Nb = 4;
   localparam int Nk = 4;
   localparam int Nr = Nk + 6;
   localparam int NW = Nb * (Nr + 1);
   localparam int IW = 6;
endpackage

package aes_wire;
   import aes_const::*;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } state_t;

   typedef struct packed {
      state_t          state;
      logic [IW-1:0]   idx;
      logic [2:0]      kpos;
      logic [7:0]      rcon;
      logic            busy;
      logic            ready;
   } reg_type;

   localparam reg_type REG_RST = '{
      state: IDLE,
      idx:   '0,
      kpos:  '0,
      rcon:  8'h01,
      busy:  1'b0,
      ready: 1'b0
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
// Purely combinational.
module aes_subword (
   input  logic [31:0] State_in,
   input  logic [7:0]  SBox [0:255],
   output logic [31:0] State_out
);
   assign State_out = {SBox[State_in[31:24]],
                       SBox[State_in[23:16]],
                       SBox[State_in[15:8]],
                       SBox[State_in[7:0]]};
endmodule

// File: rtl/aes_kexp_state.sv
// AES key expansion: loads the cipher key on Start, then
// produces one expanded word per cycle until the schedule is full.
module aes_kexp_state
   import aes_const::*;
   import aes_wire::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  SBox [0:255],
   input  logic [7:0]  Key_in [0:4*Nk-1],
   input  logic        Start,
   output logic [31:0] KExp [0:NW-1],
   output logic        Busy,
   output logic        Ready_out
);
   // kpos tracks i mod Nk so no divider is needed for Nk=6
   localparam logic [IW-1:0] NK_W   = IW'(Nk);
   localparam logic [IW-1:0] LAST_W = IW'(NW - 1);
   localparam logic [2:0]    KLAST  = 3'(Nk - 1);

   reg_type     r, rin;
   logic [31:0] kexp_q [0:NW-1];
   logic        load, wr;
   logic [31:0] prev_w, base_w, sub_in, sub_out;
   logic [31:0] temp_w, new_w;

   assign prev_w = kexp_q[r.idx - 6'd1];
   assign base_w = kexp_q[r.idx - NK_W];
   assign sub_in = (r.kpos == 3'd0)
                 ? {prev_w[23:0], prev_w[31:24]}
                 : prev_w;

   aes_subword u_subword (
      .State_in  (sub_in),
      .SBox      (SBox),
      .State_out (sub_out)
   );

   // Word recurrence: pick temp, then xor with w[i-Nk]
   always_comb begin
      temp_w = prev_w;
      if (r.kpos == 3'd0)
         temp_w = sub_out ^ {r.rcon, 24'h0};
      else if (Nk > 6 && r.kpos == 3'd4)
         temp_w = sub_out;
      new_w = base_w ^ temp_w;
   end

   // FSM next state and control
   always_comb begin
      rin  = r;
      load = 1'b0;
      wr   = 1'b0;
      unique case (r.state)
         IDLE, DONE: begin
            if (Start) begin
               load      = 1'b1;
               rin.state = EXPAND;
               rin.idx   = NK_W;
               rin.kpos  = 3'd0;
               rin.rcon  = 8'h01;
               rin.busy  = 1'b1;
               rin.ready = 1'b0;
            end
         end
         EXPAND: begin
            wr       = 1'b1;
            rin.idx  = r.idx + 6'd1;
            rin.kpos = (r.kpos == KLAST) ? 3'd0 : r.kpos + 3'd1;
            if (r.kpos == 3'd0)
               rin.rcon = xtime(r.rcon);
            if (r.idx == LAST_W) begin
               rin.state = DONE;
               rin.busy  = 1'b0;
               rin.ready = 1'b1;
            end
         end
         default: rin = REG_RST;
      endcase
   end

   // FSM register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst)
         r <= REG_RST;
      else
         r <= rin;
   end

   // Expanded-key storage: key load, one word per cycle, or clear
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NW; k++)
            kexp_q[k] <= '0;
      end else if (load) begin
         for (int k = 0; k < Nk; k++)
            kexp_q[k] <= {Key_in[4*k], Key_in[4*k+1],
                          Key_in[4*k+2], Key_in[4*k+3]};
      end else if (wr) begin
         kexp_q[r.idx] <= new_w;
      end
   end

   assign KExp      = kexp_q;
   assign Busy      = r.busy;
   assign Ready_out = r.ready;
endmodule

// File: tb/tb_aes_kexp_state.sv
// Directed bench for aes_kexp_state (AES-128 build).
// Expected words are the published AES-128 schedule values.
module tb_aes_kexp_state;
   import aes_const::*;

   localparam logic [2047:0] SB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_Z  = 128'h0;
   localparam logic [127:0] KEY_G  = 128'hdeadbeef0123456789abcdeffeedface;

   logic        clk, rst, Start, Busy, Ready_out;
   logic [7:0]  sbox   [0:255];
   logic [7:0]  key_in [0:4*Nk-1];
   logic [31:0] kexp   [0:NW-1];

   int checks = 0;
   int errors = 0;

   aes_kexp_state dut (
      .clk       (clk),
      .rst       (rst),
      .SBox      (sbox),
      .Key_in    (key_in),
      .Start     (Start),
      .KExp      (kexp),
      .Busy      (Busy),
      .Ready_out (Ready_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %08h want %08h", tag, obs, exp);
      end
   endtask

   task automatic set_key(input logic [127:0] k);
      for (int i = 0; i < 16; i++)
         key_in[i] = k[127-8*i -: 8];
   endtask

   // mode 0: plain, 1: Start pulses + key change, 2: reset at edge 20
   task automatic expand(input string tag, input int mode,
                         output int edges);
      Start = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      edges = 1;
      chk({tag, "_busy1"}, 32'(Busy), 32'd1);
      chk({tag, "_rdy1"}, 32'(Ready_out), 32'd0);
      while (edges < 100) begin
         if (mode == 1 && (edges + 1 == 5 || edges + 1 == 17)) begin
            Start = 1'b1;
            set_key(KEY_G);
         end
         if (mode == 2 && edges + 1 == 20)
            rst = 1'b1;
         @(posedge clk);
         #1;
         edges++;
         Start = 1'b0;
         if (mode == 2 && edges == 20) begin
            rst = 1'b0;
            return;
         end
         if (Ready_out)
            break;
      end
      chk({tag, "_lat"}, 32'(edges), 32'd41);
   endtask

   task automatic chk_a1(input string tag);
      chk({tag, "_w0"},  kexp[0],  32'h2b7e1516);
      chk({tag, "_w4"},  kexp[4],  32'ha0fafe17);
      chk({tag, "_w5"},  kexp[5],  32'h88542cb1);
      chk({tag, "_w7"},  kexp[7],  32'h2a6c7605);
      chk({tag, "_w8"},  kexp[8],  32'hf2c295f2);
      chk({tag, "_w40"}, kexp[40], 32'hd014f9a8);
      chk({tag, "_w43"}, kexp[43], 32'hb6630ca6);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_rdy"}, 32'(Ready_out), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      logic [31:0] orr;
      for (int i = 0; i < 256; i++)
         sbox[i] = SB[2047-8*i -: 8];
      rst   = 1'b1;
      Start = 1'b1;
      set_key(KEY_A1);
      repeat (2) @(posedge clk);
      #1;
      Start = 1'b0;
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_rdy", 32'(Ready_out), 32'd0);
      chk("rst_w0", kexp[0], 32'h0);
      chk("rst_w43", kexp[43], 32'h0);
      rst = 1'b0;

      expand("a1", 0, e);
      chk_a1("a1");

      set_key(KEY_Z);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_rdy", 32'(Ready_out), 32'd1);
      chk("hold_w4", kexp[4], 32'ha0fafe17);
      chk("hold_w43", kexp[43], 32'hb6630ca6);

      expand("zero", 0, e);
      chk("zero_w4",  kexp[4],  32'h62636363);
      chk("zero_w7",  kexp[7],  32'h62636363);
      chk("zero_w8",  kexp[8],  32'h9b9898c9);
      chk("zero_w40", kexp[40], 32'hb4ef5bcb);
      chk("zero_w43", kexp[43], 32'h6f8f188e);

      set_key(KEY_A1);
      expand("re", 0, e);
      chk_a1("re");

      set_key(KEY_Z);
      @(posedge clk);
      #1;
      expand("zero2", 0, e);
      chk("zero2_w43", kexp[43], 32'h6f8f188e);

      set_key(KEY_A1);
      expand("ign", 1, e);
      chk_a1("ign");

      set_key(KEY_A1);
      expand("rst20", 2, e);
      chk("rst20_busy", 32'(Busy), 32'd0);
      chk("rst20_rdy", 32'(Ready_out), 32'd0);
      orr = '0;
      for (int i = 0; i < NW; i++)
         orr |= kexp[i];
      chk("rst20_zero", orr, 32'h0);

      set_key(KEY_A1);
      expand("post", 0, e);
      chk_a1("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
